// File: rtl/flatten_stream.sv
// Serialises one CHW-packed feature-map frame into LANES-element beats (CHW or HWC order).
// Double-buffered (active + pending slot) so consecutive frames stream without a bubble.
module flatten_stream #(
   parameter int unsigned BITWIDTH    = 16,
   parameter int unsigned DATAWIDTH   = 6,
   parameter int unsigned DATAHEIGHT  = 6,
   parameter int unsigned DATACHANNEL = 3,
   parameter int unsigned LANES       = 2,
   parameter int unsigned CNT_WIDTH   = 10
) (
   input  logic                                                   clk,
   input  logic                                                   rst_n,
   input  logic                                                   clken,
   input  logic [BITWIDTH*DATAWIDTH*DATAHEIGHT*DATACHANNEL-1:0]   data_in,
   input  logic                                                   data_in_valid,
   output logic                                                   data_in_ready,
   input  logic                                                   order_hwc,
   output logic [BITWIDTH*LANES-1:0]                              data_out,
   output logic                                                   data_out_valid,
   input  logic                                                   data_out_ready,
   output logic                                                   data_out_last,
   output logic                                                   done
);

   localparam int unsigned TOTAL   = DATAWIDTH * DATAHEIGHT * DATACHANNEL;
   localparam int unsigned BEATS   = TOTAL / LANES;
   localparam int unsigned FRAME_W = BITWIDTH * TOTAL;
   localparam int unsigned BEAT_W  = BITWIDTH * LANES;
   localparam int unsigned IDX_W   = $clog2(TOTAL + 1);
   localparam logic [CNT_WIDTH-1:0] K_LAST = CNT_WIDTH'(BEATS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] k_q, k_d;
   logic [FRAME_W-1:0]   act_q, act_d, pend_q, pend_d;
   logic                 act_hwc_q, act_hwc_d;
   logic                 pend_hwc_q, pend_hwc_d;
   logic                 pend_full_q, pend_full_d;
   logic                 done_d;
   logic                 capture, accept, finish;
   logic [BEAT_W-1:0]    beat;
   logic [IDX_W-1:0]     pos, ch, col, row, src;

   assign data_in_ready = ~pend_full_q;
   assign capture       = data_in_valid & ~pend_full_q;
   assign accept        = (state_q == SEND) & data_out_ready;
   assign finish        = accept & (k_q == K_LAST);

   // Next-state: slot management and beat counter
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      act_d       = act_q;
      act_hwc_d   = act_hwc_q;
      pend_d      = pend_q;
      pend_hwc_d  = pend_hwc_q;
      pend_full_d = pend_full_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_full_q) begin
               act_d       = pend_q;
               act_hwc_d   = pend_hwc_q;
               pend_full_d = 1'b0;
               state_d     = SEND;
               k_d         = '0;
            end else if (capture) begin
               act_d     = data_in;
               act_hwc_d = order_hwc;
               state_d   = SEND;
               k_d       = '0;
            end
         end
         SEND: begin
            if (finish) begin
               done_d = 1'b1;
               k_d    = '0;
               if (pend_full_q) begin
                  act_d       = pend_q;
                  act_hwc_d   = pend_hwc_q;
                  pend_full_d = 1'b0;
               end else if (capture) begin
                  // pending is empty, so the new frame bypasses straight into active
                  act_d     = data_in;
                  act_hwc_d = order_hwc;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (accept) k_d = k_q + CNT_WIDTH'(1);
               if (capture) begin
                  pend_d      = data_in;
                  pend_hwc_d  = order_hwc;
                  pend_full_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Gather the beat that will be presented after this edge
   always_comb begin
      beat = '0;
      pos  = '0;
      ch   = '0;
      col  = '0;
      row  = '0;
      src  = '0;
      for (int unsigned lane = 0; lane < LANES; lane++) begin
         pos = IDX_W'(k_d) * IDX_W'(LANES) + IDX_W'(lane);
         ch  = pos % IDX_W'(DATACHANNEL);
         col = (pos / IDX_W'(DATACHANNEL)) % IDX_W'(DATAWIDTH);
         row = pos / IDX_W'(DATACHANNEL * DATAWIDTH);
         src = act_hwc_d ? (ch * IDX_W'(DATAHEIGHT * DATAWIDTH) + row * IDX_W'(DATAWIDTH) + col)
                         : pos;
         beat[lane*BITWIDTH +: BITWIDTH] = act_d[src*BITWIDTH +: BITWIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         k_q            <= '0;
         act_hwc_q      <= 1'b0;
         pend_hwc_q     <= 1'b0;
         pend_full_q    <= 1'b0;
         done           <= 1'b0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         data_out_last  <= 1'b0;
      end else if (clken) begin
         state_q        <= state_d;
         k_q            <= k_d;
         act_hwc_q      <= act_hwc_d;
         pend_hwc_q     <= pend_hwc_d;
         pend_full_q    <= pend_full_d;
         done           <= done_d;
         data_out       <= (state_d == SEND) ? beat : '0;
         data_out_valid <= (state_d == SEND);
         data_out_last  <= (state_d == SEND) && (k_d == K_LAST);
      end
   end

   // Frame storage needs no reset: contents are only observed behind the slot flags
   always_ff @(posedge clk) begin
      if (clken) begin
         act_q  <= act_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: tb/tb_flatten_stream.sv
// Self-checking bench for flatten_stream on a 2x2x3 frame, 2 lanes, against a loop-order model.
module tb_flatten_stream;

   localparam int unsigned BW    = 16;
   localparam int unsigned W     = 2;
   localparam int unsigned H     = 2;
   localparam int unsigned C     = 3;
   localparam int unsigned L     = 2;
   localparam int unsigned TOTAL = W * H * C;
   localparam int unsigned BEATS = TOTAL / L;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  clken = 1'b1;
   logic [BW*TOTAL-1:0]   data_in = '0;
   logic                  data_in_valid = 1'b0;
   logic                  data_in_ready;
   logic                  order_hwc = 1'b0;
   logic [BW*L-1:0]       data_out;
   logic                  data_out_valid;
   logic                  data_out_ready = 1'b1;
   logic                  data_out_last;
   logic                  done;

   flatten_stream #(
      .BITWIDTH(BW), .DATAWIDTH(W), .DATAHEIGHT(H), .DATACHANNEL(C), .LANES(L), .CNT_WIDTH(10)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clken(clken),
      .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
      .order_hwc(order_hwc),
      .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
      .data_out_last(data_out_last), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] obs_q[$];
   int            beat_cyc[$];
   bit            beat_last[$];
   int            done_cyc[$];
   int            hold_err = 0;
   bit            stop = 1'b0;

   logic          prev_stall = 1'b0;
   logic [BW*L-1:0] prev_do = '0;
   logic          prev_v = 1'b0;
   logic          prev_l = 1'b0;

   // Observe transfers and stall stability midway between edges
   always @(negedge clk) begin
      if (prev_stall && (data_out !== prev_do || data_out_valid !== prev_v || data_out_last !== prev_l))
         hold_err++;
      if (rst_n && clken && data_out_valid && data_out_ready) begin
         for (int l = 0; l < L; l++) obs_q.push_back(data_out[l*BW +: BW]);
         beat_cyc.push_back(cyc);
         beat_last.push_back(data_out_last);
      end
      if (done && clken) done_cyc.push_back(cyc);
      prev_stall = rst_n && data_out_valid && !(data_out_ready && clken);
      prev_do    = data_out;
      prev_v     = data_out_valid;
      prev_l     = data_out_last;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference order: CHW is the storage order; HWC walks h, then w, then c innermost
   task automatic model_frame(input logic [BW*TOTAL-1:0] v, input bit hwc);
      if (!hwc) begin
         for (int i = 0; i < TOTAL; i++) exp_q.push_back(v[i*BW +: BW]);
      end else begin
         for (int h = 0; h < H; h++)
            for (int w = 0; w < W; w++)
               for (int c = 0; c < C; c++)
                  exp_q.push_back(v[(c*H*W + h*W + w)*BW +: BW]);
      end
   endtask

   function automatic logic [BW*TOTAL-1:0] rand_frame();
      logic [BW*TOTAL-1:0] v;
      for (int i = 0; i < TOTAL; i++) v[i*BW +: BW] = BW'($urandom);
      return v;
   endfunction

   function automatic logic [BW*TOTAL-1:0] ramp_frame();
      logic [BW*TOTAL-1:0] v;
      for (int i = 0; i < TOTAL; i++) v[i*BW +: BW] = BW'(i);
      return v;
   endfunction

   task automatic clear_obs();
      exp_q.delete();
      obs_q.delete();
      beat_cyc.delete();
      beat_last.delete();
      done_cyc.delete();
      hold_err = 0;
   endtask

   // Offer a frame until captured; cap_cyc is the cycle before the capture edge (-1 on timeout)
   task automatic offer(input logic [BW*TOTAL-1:0] v, input bit hwc, output int cap_cyc);
      data_in       = v;
      order_hwc     = hwc;
      data_in_valid = 1'b1;
      cap_cyc       = -1;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (data_in_ready && clken && rst_n) begin
            cap_cyc = cyc;
            break;
         end
      end
      @(posedge clk);
      #1;
      data_in_valid = 1'b0;
      order_hwc     = ~hwc;
      data_in       = rand_frame();
      if (cap_cyc >= 0) model_frame(v, hwc);
   endtask

   task automatic wait_drain(input int ndone, output bit ok);
      int t = 0;
      while ((obs_q.size() < exp_q.size() || done_cyc.size() < ndone) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      ok = (t < 3000);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", data_out_valid); end
      n_cmp++; if (data_out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", data_out_last); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_out); end
      n_cmp++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", data_in_ready); end
      rst_n = 1'b1;
      clken = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_chw();
      int cap;
      bit ok;
      clear_obs();
      data_out_ready = 1'b1;
      offer(ramp_frame(), 1'b0, cap);
      wait_drain(1, ok);
      n_cmp++; if (!ok || cap < 0) begin n_err++; $display("FAIL chw_timeout: cap=%0d ok=%0d", cap, ok); end
      n_cmp++; if (obs_q.size() != TOTAL) begin n_err++; $display("FAIL chw_count: got %0d want %0d", obs_q.size(), TOTAL); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL chw_elem[%0d]: got %0h want %0h", i, obs_q[i], exp_q[i]); end
      end
      for (int i = 0; i < beat_last.size(); i++) begin
         n_cmp++;
         if (beat_last[i] !== (i == BEATS - 1)) begin n_err++; $display("FAIL chw_last[%0d]: got %0b want %0b", i, beat_last[i], (i == BEATS - 1)); end
      end
      if (beat_cyc.size() == BEATS) begin
         n_cmp++;
         if (beat_cyc[0] != cap + 1) begin n_err++; $display("FAIL chw_latency: beat0 at %0d want %0d", beat_cyc[0], cap + 1); end
         n_cmp++;
         if (done_cyc.size() != 1 || done_cyc[0] != beat_cyc[BEATS-1] + 1) begin
            n_err++; $display("FAIL chw_done: count %0d first at %0d want 1 at %0d", done_cyc.size(),
                              (done_cyc.size() > 0) ? done_cyc[0] : -1, beat_cyc[BEATS-1] + 1);
         end
      end
   endtask

   task automatic test_hwc();
      int cap;
      bit ok;
      int ref_seq[TOTAL] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
      clear_obs();
      offer(ramp_frame(), 1'b1, cap);
      wait_drain(1, ok);
      n_cmp++; if (!ok || obs_q.size() != TOTAL) begin n_err++; $display("FAIL hwc_count: got %0d want %0d", obs_q.size(), TOTAL); end
      for (int i = 0; i < TOTAL && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== BW'(ref_seq[i])) begin n_err++; $display("FAIL hwc_elem[%0d]: got %0d want %0d", i, obs_q[i], ref_seq[i]); end
      end
      n_cmp++; if (done_cyc.size() != 1) begin n_err++; $display("FAIL hwc_done: got %0d pulses want 1", done_cyc.size()); end
   endtask

   task automatic test_random_ready();
      int cap;
      bit ok;
      clear_obs();
      stop = 1'b0;
      fork
         begin
            while (!stop) begin
               @(posedge clk);
               #1;
               data_out_ready = 1'($urandom % 2);
            end
         end
      join_none
      for (int f = 0; f < 3; f++) offer(rand_frame(), 1'($urandom % 2), cap);
      wait_drain(3, ok);
      stop = 1'b1;
      @(posedge clk);
      #2;
      data_out_ready = 1'b1;
      n_cmp++; if (!ok || obs_q.size() != 3 * TOTAL) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), 3 * TOTAL); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_elem[%0d]: got %0h want %0h", i, obs_q[i], exp_q[i]); end
      end
      for (int i = 0; i < beat_last.size(); i++) begin
         n_cmp++;
         if (beat_last[i] !== (i % BEATS == BEATS - 1)) begin n_err++; $display("FAIL rnd_last[%0d]: got %0b", i, beat_last[i]); end
      end
      n_cmp++; if (done_cyc.size() != 3) begin n_err++; $display("FAIL rnd_done: got %0d pulses want 3", done_cyc.size()); end
      n_cmp++; if (hold_err != 0) begin n_err++; $display("FAIL rnd_hold: %0d stall violations want 0", hold_err); end
   endtask

   task automatic test_back_to_back();
      int cap;
      bit ok;
      clear_obs();
      data_out_ready = 1'b1;
      offer(rand_frame(), 1'b0, cap);
      offer(rand_frame(), 1'b1, cap);
      n_cmp++; if (data_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready: got %b want 0 while pending full", data_in_ready); end
      wait_drain(2, ok);
      n_cmp++; if (!ok || obs_q.size() != 2 * TOTAL) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), 2 * TOTAL); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_elem[%0d]: got %0h want %0h", i, obs_q[i], exp_q[i]); end
      end
      if (beat_cyc.size() == 2 * BEATS) begin
         n_cmp++;
         if (beat_cyc[BEATS] != beat_cyc[BEATS-1] + 1) begin n_err++; $display("FAIL b2b_gap: frame B beat0 at %0d want %0d", beat_cyc[BEATS], beat_cyc[BEATS-1] + 1); end
      end
      n_cmp++; if (done_cyc.size() != 2) begin n_err++; $display("FAIL b2b_done: got %0d pulses want 2", done_cyc.size()); end
   endtask

   task automatic test_simul_capture();
      int cap;
      bit ok;
      clear_obs();
      data_out_ready = 1'b1;
      offer(rand_frame(), 1'b1, cap);
      for (int t = 0; t < 100 && !(data_out_valid && data_out_last); t++) begin
         @(posedge clk);
         #1;
      end
      offer(rand_frame(), 1'b0, cap);
      n_cmp++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL sim_ready: got %b want 1 (pending empty)", data_in_ready); end
      n_cmp++; if (data_out_valid !== 1'b1 || data_out_last !== 1'b0) begin n_err++; $display("FAIL sim_beat0: valid %b last %b want 1 0", data_out_valid, data_out_last); end
      wait_drain(2, ok);
      n_cmp++; if (!ok || obs_q.size() != 2 * TOTAL) begin n_err++; $display("FAIL sim_count: got %0d want %0d", obs_q.size(), 2 * TOTAL); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL sim_elem[%0d]: got %0h want %0h", i, obs_q[i], exp_q[i]); end
      end
      if (beat_cyc.size() == 2 * BEATS) begin
         n_cmp++;
         if (beat_cyc[BEATS] != beat_cyc[BEATS-1] + 1) begin n_err++; $display("FAIL sim_gap: beat0 at %0d want %0d", beat_cyc[BEATS], beat_cyc[BEATS-1] + 1); end
      end
      n_cmp++; if (done_cyc.size() != 2) begin n_err++; $display("FAIL sim_done: got %0d pulses want 2", done_cyc.size()); end
   endtask

   task automatic test_clken();
      int cap;
      bit ok;
      clear_obs();
      data_out_ready = 1'b1;
      stop = 1'b0;
      fork
         begin
            while (!stop) begin
               @(posedge clk);
               #1;
               clken = ~clken;
            end
         end
      join_none
      offer(rand_frame(), 1'b1, cap);
      wait_drain(1, ok);
      stop = 1'b1;
      @(posedge clk);
      #2;
      clken = 1'b1;
      n_cmp++; if (!ok || obs_q.size() != TOTAL) begin n_err++; $display("FAIL clken_count: got %0d want %0d", obs_q.size(), TOTAL); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL clken_elem[%0d]: got %0h want %0h", i, obs_q[i], exp_q[i]); end
      end
      for (int i = 1; i < beat_cyc.size(); i++) begin
         n_cmp++;
         if (beat_cyc[i] - beat_cyc[i-1] != 2) begin n_err++; $display("FAIL clken_spacing[%0d]: got %0d want 2", i, beat_cyc[i] - beat_cyc[i-1]); end
      end
      n_cmp++; if (done_cyc.size() != 1) begin n_err++; $display("FAIL clken_done: got %0d pulses want 1", done_cyc.size()); end
      n_cmp++; if (hold_err != 0) begin n_err++; $display("FAIL clken_hold: %0d changes on frozen edges want 0", hold_err); end
   endtask

   task automatic test_reset_mid();
      int cap;
      bit ok;
      clear_obs();
      data_out_ready = 1'b1;
      offer(rand_frame(), 1'b0, cap);
      for (int t = 0; t < 100 && obs_q.size() < 3 * L; t++) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_cmp++; if (data_out_valid !== 1'b0 || data_out_last !== 1'b0 || data_out !== '0) begin
         n_err++; $display("FAIL rstmid_out: valid %b last %b data %h want all 0", data_out_valid, data_out_last, data_out);
      end
      n_cmp++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", data_in_ready); end
      repeat (BEATS + 3) @(posedge clk);
      #1;
      n_cmp++; if (done_cyc.size() != 0) begin n_err++; $display("FAIL rstmid_nodone: got %0d pulses want 0", done_cyc.size()); end
      n_cmp++; if (obs_q.size() != 3 * L) begin n_err++; $display("FAIL rstmid_stop: got %0d elems want %0d", obs_q.size(), 3 * L); end
      clear_obs();
      offer(rand_frame(), 1'b1, cap);
      wait_drain(1, ok);
      n_cmp++; if (!ok || obs_q.size() != TOTAL) begin n_err++; $display("FAIL rstmid_count: got %0d want %0d", obs_q.size(), TOTAL); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rstmid_elem[%0d]: got %0h want %0h", i, obs_q[i], exp_q[i]); end
      end
      n_cmp++; if (done_cyc.size() != 1) begin n_err++; $display("FAIL rstmid_done: got %0d pulses want 1", done_cyc.size()); end
   endtask

   initial begin
      test_reset();
      test_chw();
      test_hwc();
      test_random_ready();
      test_back_to_back();
      test_simul_capture();
      test_clken();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/flatten_stream.md
# flatten_stream

Parametrised successor to the single-frame flattener. It serialises one feature-map frame (W×H×C elements, CHW-packed) into a stream of LANES elements per beat, in either CHW or HWC order. It has ready/valid back-pressure on both sides and a two-slot frame buffer, so back-to-back frames stream with no bubble. It sits between the last conv/pool stage and the fully-connected layer.

## Interface
- BITWIDTH, 16: bits per element
- DATAWIDTH, 6: frame width W
- DATAHEIGHT, 6: frame height H
- DATACHANNEL, 3: channel count C
- LANES, 2: elements per output beat; must divide TOTAL = W*H*C
- CNT_WIDTH, 10: beat counter width; must hold TOTAL/LANES-1
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- clken  in  1  global enable; when low all state frozen, no transfer occurs
- data_in  in  BITWIDTH*TOTAL  frame; element (c,h,w) at index c*H*W+h*W+w, index i in bits [i*BITWIDTH +: BITWIDTH]
- data_in_valid  in  1  frame offered
- data_in_ready  out  1  pending slot empty (combinational from registered state)
- order_hwc  in  1  order for the offered frame, captured with it: 0=CHW, 1=HWC
- data_out  out  BITWIDTH*LANES  beat; lane 0 (earliest element) in low bits
- data_out_valid  out  1  beat valid
- data_out_ready  in  1  downstream accepts beat
- data_out_last  out  1  marks final beat of a frame, qualified by data_out_valid
- done  out  1  one-cycle pulse after the final beat of a frame is accepted

## Operation
- Transfers happen only on edges with clken=1.
  - Input capture: data_in_valid & data_in_ready.
  - Output accept: data_out_valid & data_out_ready.
- Storage: active slot (being sent) and pending slot, each holding frame plus order bit.
- States:
  - IDLE (active empty).
  - SEND (active full, beat counter k in 0..BEATS-1, BEATS = TOTAL/LANES).
- IDLE transitions:
  - If pending is full, promote it to active. Otherwise, on input capture, load the input directly into active (bypass). Go to SEND with k=0.
- SEND behaviour:
  - On accept with k<BEATS-1: k increments.
  - On accept with k=BEATS-1: pulse done next cycle.
    - Pending full: promote it, k=0, stay in SEND.
    - Else, input capture on the same edge: load the input into active, k=0, stay in SEND.
    - Else: go to IDLE.
- Input captured while SEND and not finishing goes to pending. data_in_ready=0 while pending is full.
- Element order for output position j = k*LANES+lane:
  - CHW: flat index j.
  - HWC: c=j%C, w=(j/C)%W, h=j/(C*W); index c*H*W+h*W+w.
- data_out_last = (k==BEATS-1) while in SEND.
- Index arithmetic is unsigned and sized to hold TOTAL-1; no wrap beyond BEATS-1.

## Timing
- Reset values (rst_n low at an edge, regardless of clken): state IDLE, both slots empty, k=0, data_out=0, data_out_valid=0, data_out_last=0, done=0. Hence data_in_ready=1 after reset.
- Reset mid-frame discards both slots; no done pulse.
- Latency: input captured at edge N while IDLE gives beat 0 valid in the cycle after N.
- Registered output: data_out, data_out_valid and data_out_last update on the edge.
- Hold rule: while data_out_valid=1 and data_out_ready=0 (or clken=0), data_out, data_out_valid and data_out_last hold stable.
- Back-to-back: with pending full, beat 0 of the next frame is valid the cycle after the last beat is accepted (zero bubble). Sustained throughput is LANES elements per clock.
- done: asserted in the cycle following the last-beat accept edge, for exactly one clken=1 cycle; held if clken drops.
- order_hwc is sampled only at capture. Changing it mid-frame has no effect on the frame in flight.
- Simultaneous last-beat accept and input capture with pending empty: the input goes to active, and pending stays empty.

## Test plan
- W=H=2, C=3, LANES=2, CHW, data_in elements 0..11, ready=1 → 6 beats {1,0},{3,2},…,{11,10}; last on beat 6; done 1 cycle later; first valid 1 cycle after capture.
- Same frame, order_hwc=1 → element sequence 0,4,8,1,5,9,2,6,10,3,7,11 packed two per beat.
- Random data_out_ready (50%) → beats held stable while stalled; no loss or duplication across 3 frames; done count = 3.
- Two frames offered back-to-back with ready=1 → data_in_ready drops while pending full; zero-cycle gap between last of frame A and beat 0 of frame B; exactly two done pulses.
- clken toggled every other cycle during streaming → output sequence identical to the clken=1 run, stretched 2×; no transfers on clken=0 edges.
- rst_n low for one edge at beat 3 of a frame → all outputs 0 next cycle; data_in_ready=1; no done; next frame streams correctly from beat 0.
